// File: rtl/lsu_pkg.sv
// Shared definitions for mem_stage_lsu: funct3 encodings, FSM states and access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // Unsigned variants share the size of their signed forms; reserved codes act as words.
    function automatic lsu_size_t decode_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// lsu_load_align: picks the byte/half addressed within a memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = rdata[{addr, 3'b000} +: 8];
    assign half_s = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_BU:   data = {24'd0, byte_s};
            F3_HU:   data = {16'd0, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake to data memory, store lane formatting, load extension.
// Optional macro LSU_STALL_CNT_EN adds a saturating stall_cycles counter output.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] load_data,
    output logic            StallM,
    output logic            MisalignM,
`ifdef LSU_STALL_CNT_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    lsu_state_t      state;
    lsu_size_t       size;
    logic            access;
    logic            is_store;
    logic            misalign;
    logic            aligned;
    logic [3:0]      store_be;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] load_p1;

    assign access   = MemReadM | MemWriteM;
    assign is_store = MemWriteM;
    assign size     = decode_size(funct3M);

    always_comb begin
        misalign = 1'b0;
        case (size)
            SZ_H:    misalign = ALUResultM[0];
            SZ_W:    misalign = |ALUResultM[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign aligned = access & ~misalign;

    // Store lanes are derived straight from the held MEM inputs, so they stay stable while waiting for gnt.
    always_comb begin
        store_be   = 4'b1111;
        dmem_wdata = WriteDataM;
        case (size)
            SZ_B: begin
                store_be   = 4'b0001 << ALUResultM[1:0];
                dmem_wdata = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                store_be   = 4'b0011 << ALUResultM[1:0];
                dmem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                dmem_wdata = WriteDataM;
            end
        endcase
    end

    assign dmem_be   = is_store ? store_be : 4'b1111;
    assign dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};

    // Control outputs are forced low while clr is held so reset leaves the bus quiet.
    assign dmem_req  = ~clr & (((state == IDLE) & aligned) | (state == WAIT_GNT));
    assign dmem_we   = dmem_req & is_store;
    assign StallM    = ~clr & aligned & (state != DONE);
    assign MisalignM = ~clr & access & misalign & (state == IDLE);
    assign load_data = load_p1;

    lsu_load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (ALUResultM[1:0]),
        .funct3 (funct3M),
        .data   (load_ext)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            load_p1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aligned) begin
                        if (dmem_gnt) state <= is_store ? DONE : WAIT_RSP;
                        else          state <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (dmem_gnt) state <= is_store ? DONE : WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (dmem_rvalid) begin
                        load_p1 <= load_ext;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr)         stall_cycles <= '0;
        else if (StallM) stall_cycles <= sat_inc(stall_cycles);
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized accesses against a cycle-count model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        clr;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] load_data;
    logic        StallM, MisalignM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
`ifdef LSU_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_load = 32'd0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .funct3M     (funct3M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .load_data   (load_data),
        .StallM      (StallM),
        .MisalignM   (MisalignM),
`ifdef LSU_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access width in bytes.
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdat);
        int          sz = ref_size(f3);
        logic [31:0] v;
        v = rdat >> (8 * a[1:0]);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after the access completes.
    task automatic run_access(input logic wr, input logic rd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int gd, input int rsd);
        int          sz;
        int          last;
        logic        is_st;
        logic        mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        is_st = wr;
        sz    = ref_size(f3);
        mis   = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
        MemWriteM = wr; MemReadM = rd; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        if (mis) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom_range(1)); dmem_rdata = $urandom;
            #1;
            check("mis_flag",  {31'd0, MisalignM}, 32'd1);
            check("mis_stall", {31'd0, StallM},    32'd0);
            check("mis_req",   {31'd0, dmem_req},  32'd0);
            @(negedge clk);
            check("mis_load", load_data, exp_load);
            return;
        end
        last = is_st ? gd + 1 : gd + 2 + rsd;
        e_be = is_st ? 4'(((1 << sz) - 1) << addr[1:0]) : 4'hF;
        e_wd = (sz == 1) ? wd[7:0] * 32'h0101_0101 : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        for (int k = 0; k <= last; k++) begin
            dmem_gnt = (k == gd);
            if (!is_st && k > gd && k < last) begin
                dmem_rvalid = (k == last - 1);
                dmem_rdata  = (k == last - 1) ? rdat : $urandom;
            end else begin
                dmem_rvalid = 1'($urandom_range(1));
                dmem_rdata  = $urandom;
            end
            if (k == last - 1 && !is_st) exp_load = ref_load(f3, addr, rdat);
            #1;
            check("stall", {31'd0, StallM},   {31'd0, k < last});
            check("req",   {31'd0, dmem_req}, {31'd0, k <= gd});
            if (k <= gd) begin
                check("we",    {31'd0, dmem_we}, {31'd0, is_st});
                check("addr",  dmem_addr, addr & 32'hFFFF_FFFC);
                check("be",    {28'd0, dmem_be}, {28'd0, e_be});
                if (is_st) check("wdata", dmem_wdata, e_wd);
            end
            if (k == last) check("load_data", load_data, exp_load);
            @(negedge clk);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic idle_cycle();
        MemWriteM = 1'b0; MemReadM = 1'b0; dmem_gnt = 1'b0;
        dmem_rvalid = 1'($urandom_range(1)); dmem_rdata = $urandom;
        #1;
        check("idle_req",   {31'd0, dmem_req},  32'd0);
        check("idle_stall", {31'd0, StallM},    32'd0);
        check("idle_mis",   {31'd0, MisalignM}, 32'd0);
        @(negedge clk);
        check("idle_load", load_data, exp_load);
    endtask

    initial begin
        clr = 1'b1;
        MemWriteM = 1'b1; MemReadM = 1'b1; funct3M = 3'b000;
        ALUResultM = 32'h0000_1237; WriteDataM = 32'h0000_00A5;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #1;
        check("rst_req",   {31'd0, dmem_req},  32'd0);
        check("rst_we",    {31'd0, dmem_we},   32'd0);
        check("rst_stall", {31'd0, StallM},    32'd0);
        check("rst_mis",   {31'd0, MisalignM}, 32'd0);
        check("rst_load",  load_data, 32'd0);
        check("rst_addr",  dmem_addr, 32'h0000_1234);
        check("rst_be",    {28'd0, dmem_be}, 32'h8);
        check("rst_wdata", dmem_wdata, 32'hA5A5_A5A5);
`ifdef LSU_STALL_CNT_EN
        check("rst_stall_cnt", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        MemWriteM = 1'b0; MemReadM = 1'b0;
        clr = 1'b0;
        @(negedge clk);

        // Two back-to-back word loads with one-cycle gnt and rvalid delays.
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 1, 1);
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'd0, 32'h2468_ACE0, 1, 1);
`ifdef LSU_STALL_CNT_EN
        check("stall_cnt", stall_cycles, 32'd8);
`endif

        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1);
        check("lw_value", load_data, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0);
        check("lb_value", load_data, 32'hFFFF_FF80);
        run_access(1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0);
        check("lbu_value", load_data, 32'h0000_0080);
        run_access(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_0000, 0, 0);
        check("lhu_value", load_data, 32'h0000_80FF);
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'd0, 3, 0);
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'd0, 32'd0, 0, 0);
        idle_cycle();

        // Reset while waiting for the read response; the late rvalid must be dropped.
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0400;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        #1;
        check("clr_req0", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("clr_stall_pre", {31'd0, StallM},   32'd1);
        check("clr_req_pre",   {31'd0, dmem_req}, 32'd0);
        clr = 1'b1; MemReadM = 1'b0;
        #1;
        exp_load = 32'd0;
        check("clr_load",  load_data, 32'd0);
        check("clr_stall", {31'd0, StallM}, 32'd0);
        @(negedge clk);
        clr = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("clr_late_load", load_data, 32'd0);
        check("clr_late_stall", {31'd0, StallM}, 32'd0);
        check("clr_late_req",  {31'd0, dmem_req}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(2);
            run_access(kind != 0, kind != 1, 3'($urandom_range(7)), $urandom, $urandom, $urandom,
                       $urandom_range(3), $urandom_range(3));
            if ($urandom_range(3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
- Takes MEM-stage control and datapath values, and runs a request/grant/response handshake to a variable-latency data memory.
- Formats store byte-enables and data, and sign- or zero-extends load data into load_data for the MEM/WB register.
- Raises StallM while an access is in flight; the top level uses it to hold IF through MEM and bubble WB.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock
- clr  in  1  asynchronous active-high reset
- MemReadM  in  1  load in MEM; top level drives it as ResultSrcM == 2'b01
- MemWriteM  in  1  store in MEM
- funct3M  in  3  access size/sign
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store source register value
- load_data  out  32  formatted load result to MEM/WB
- StallM  out  1  hold pipeline
- MisalignM  out  1  one-cycle pulse for a misaligned access (dropped)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, ALUResultM with [1:0] forced to 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read response valid
- dmem_rdata  in  32  read response word

Behaviour:
- Access exists when MemWriteM | MemReadM. If both are high, the access is a store.
- funct3 decode:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - 011/110/111 are treated as W.
  - BU/HU on a store are treated as B/H.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No request is issued and StallM stays 0.
  - MisalignM=1 for each cycle the instruction sits in IDLE.
  - load_data is unchanged.
- Store formatting:
  - B: be=4'b0001<<addr[1:0], wdata={4{WriteDataM[7:0]}}.
  - H: be=4'b0011<<addr[1:0], wdata={2{WriteDataM[15:0]}}.
  - W: be=4'b1111, wdata=WriteDataM.
- Loads drive be=4'b1111 and we=0.
- Load formatting: select the byte or half at addr[1:0] from dmem_rdata, then sign-extend (B/H) or zero-extend (BU/HU).
- The result is captured into a 32-bit load register on dmem_rvalid in WAIT_RSP. load_data is that register.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP, DONE.
  - IDLE: on an aligned access, dmem_req=1 combinationally. If gnt, go to WAIT_RSP (load) or DONE (store); otherwise go to WAIT_GNT.
  - WAIT_GNT: dmem_req=1 with stable address, we, be and wdata. On gnt, transition as from IDLE.
  - WAIT_RSP: dmem_req=0. On rvalid, capture data and go to DONE.
  - DONE: StallM=0 so the pipeline advances on this edge. Next state is IDLE unconditionally.
- StallM = aligned access & (state != DONE).
- Minimum latency: load 3 cycles (IDLE->WAIT_RSP->DONE); store 2 cycles.
- dmem_rvalid outside WAIT_RSP is ignored.
- Only one outstanding access is allowed.
- A gnt and rvalid in the same cycle while in IDLE: rvalid is ignored. The memory must return rvalid no earlier than the cycle after gnt.
- Reset values:
  - state=IDLE, load register=0.
  - All outputs are 0, except dmem_addr, dmem_be and dmem_wdata, which follow their combinational formatting of the MEM inputs (be/wdata per funct3M, addr=ALUResultM&~3).
- clr mid-access: returns to IDLE immediately. A late rvalid is ignored, and the abandoned request is not retried.

Optional Feature:
- LSU_STALL_CNT_EN: adds output stall_cycles[31:0].
  - Increments every cycle StallM=1.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by clr.
- Without the macro, the port and counter do not exist.

Decomposition:
- Package lsu_pkg holds:
  - localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - enum lsu_state_t {IDLE, WAIT_GNT, WAIT_RSP, DONE}.
- Sub-module lsu_load_align: combinational extractor with inputs rdata, addr[1:0] and funct3, output the extended word. It is unit-testable standalone.

Test Plan:
- LW addr 0x100, gnt immediately, rvalid 2 cycles later with rdata 0xDEADBEEF -> StallM high 3 cycles, then DONE; load_data=0xDEADBEEF; be=4'hF; dmem_addr=0x100.
- LB addr 0x103, rdata 0x80FF_0000 -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, WriteDataM 0x12345678, gnt held low 3 cycles -> req held 4 cycles with stable be=4'b0010 and wdata=0x78787878; DONE one cycle after gnt.
- LH addr 0x301 -> no dmem_req, MisalignM=1, StallM=0, load_data unchanged.
- clr asserted in WAIT_RSP, then rvalid with 0xAAAAAAAA arrives -> state IDLE, load_data=0, StallM=0.
- LSU_STALL_CNT_EN build: two back-to-back LWs, each with 1-cycle gnt delay and 1-cycle rvalid delay -> stall_cycles=8.
